// File: rtl/seg_pipe_adder_pkg.sv
// Shared types for the segmented pipelined adder.
// The operation encoding is kept here so the top and the stage agree on it.
package seg_pipe_adder_pkg;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } add_op_t;

endpackage

// File: rtl/seg_add_stage.sv
// One carry-chain segment of seg_pipe_adder: adds SEG_W bits of A and B'
// with the incoming carry and registers the whole stage payload.
// The LAST instance also produces cout/ovf/zero and, when
// SEG_PIPE_ADDER_SAT_EN is defined, clamps the sum on signed overflow.
module seg_add_stage
   import seg_pipe_adder_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SEG_W = 8,
   parameter int TAG_W = 4,
   parameter int IDX   = 0,
   parameter bit LAST  = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             valid_in,
   input  logic             sub_in,
   input  logic             carry_in,
   input  logic [TAG_W-1:0] tag_in,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic [WIDTH-1:0] sum_in,
   output logic             valid_out,
   output logic             sub_out,
   output logic             carry_out,
   output logic [TAG_W-1:0] tag_out,
   output logic [WIDTH-1:0] a_out,
   output logic [WIDTH-1:0] b_out,
   output logic [WIDTH-1:0] sum_out,
   output logic             cout_out,
   output logic             ovf_out,
   output logic             zero_out
);

   localparam int LO = IDX * SEG_W;

   add_op_t          op;
   logic [SEG_W-1:0] a_seg;
   logic [SEG_W-1:0] b_seg;
   logic [SEG_W:0]   seg_sum;
   logic [WIDTH-1:0] sum_next;
   logic             cout_next;
   logic             ovf_next;
   logic             zero_next;

   assign op      = sub_in ? OP_SUB : OP_ADD;
   assign a_seg   = a_in[LO +: SEG_W];
   assign b_seg   = (op == OP_SUB) ? ~b_in[LO +: SEG_W] : b_in[LO +: SEG_W];
   assign seg_sum = {1'b0, a_seg} + {1'b0, b_seg} + {{SEG_W{1'b0}}, carry_in};

   // Merge this segment into the partial sum; the last stage adds the flags.
   always_comb begin
      sum_next               = sum_in;
      sum_next[LO +: SEG_W]  = seg_sum[SEG_W-1:0];
      cout_next              = 1'b0;
      ovf_next               = 1'b0;
      zero_next              = 1'b0;
      if (LAST) begin
         cout_next = seg_sum[SEG_W];
         // carry into the MSB recovered from the MSB sum bit and its operands
         ovf_next  = (a_seg[SEG_W-1] ^ b_seg[SEG_W-1] ^ seg_sum[SEG_W-1]) ^ seg_sum[SEG_W];
`ifdef SEG_PIPE_ADDER_SAT_EN
         if (ovf_next) begin
            sum_next = a_seg[SEG_W-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                      : {1'b0, {(WIDTH-1){1'b1}}};
         end
`endif
         zero_next = ~|sum_next;
      end
   end

   // Stage register: shifts on the global advance, cleared by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_out <= 1'b0;
         sub_out   <= 1'b0;
         carry_out <= 1'b0;
         tag_out   <= '0;
         a_out     <= '0;
         b_out     <= '0;
         sum_out   <= '0;
         cout_out  <= 1'b0;
         ovf_out   <= 1'b0;
         zero_out  <= 1'b0;
      end else if (en) begin
         valid_out <= valid_in;
         sub_out   <= sub_in;
         carry_out <= seg_sum[SEG_W];
         tag_out   <= tag_in;
         a_out     <= a_in;
         b_out     <= b_in;
         sum_out   <= sum_next;
         cout_out  <= cout_next;
         ovf_out   <= ovf_next;
         zero_out  <= zero_next;
      end
   end

endmodule

// File: rtl/seg_pipe_adder.sv
// Pipelined WIDTH-bit add/subtract with one register stage per SEG_W-bit
// carry segment, valid/ready handshake on both sides and a passthrough tag.
// Optional output saturation on signed overflow: SEG_PIPE_ADDER_SAT_EN.
module seg_pipe_adder
   import seg_pipe_adder_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SEG_W = 8,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_sub,
   input  logic             in_cin,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf,
   output logic             out_zero,
   output logic [TAG_W-1:0] out_tag
);

   localparam int NUM_SEG = WIDTH / SEG_W;

   // Index k is the input of stage k; index k+1 is its registered output.
   logic             valid_s [NUM_SEG+1];
   logic             sub_s   [NUM_SEG+1];
   logic             carry_s [NUM_SEG+1];
   logic [TAG_W-1:0] tag_s   [NUM_SEG+1];
   logic [WIDTH-1:0] a_s     [NUM_SEG+1];
   logic [WIDTH-1:0] b_s     [NUM_SEG+1];
   logic [WIDTH-1:0] sum_s   [NUM_SEG+1];
   logic             cout_s  [NUM_SEG];
   logic             ovf_s   [NUM_SEG];
   logic             zero_s  [NUM_SEG];
   logic             advance;

   // Whole pipe moves together, bubbles included, unless the output is blocked.
   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;

   assign valid_s[0] = in_valid;
   assign sub_s[0]   = in_sub;
   assign carry_s[0] = (in_sub ? OP_SUB : OP_ADD) == OP_SUB ? 1'b1 : in_cin;
   assign tag_s[0]   = in_tag;
   assign a_s[0]     = in_a;
   assign b_s[0]     = in_b;
   assign sum_s[0]   = '0;

   generate
      for (genvar gi = 0; gi < NUM_SEG; gi++) begin : g_stage
         seg_add_stage #(
            .WIDTH (WIDTH),
            .SEG_W (SEG_W),
            .TAG_W (TAG_W),
            .IDX   (gi),
            .LAST  (gi == NUM_SEG - 1)
         ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (advance),
            .valid_in  (valid_s[gi]),
            .sub_in    (sub_s[gi]),
            .carry_in  (carry_s[gi]),
            .tag_in    (tag_s[gi]),
            .a_in      (a_s[gi]),
            .b_in      (b_s[gi]),
            .sum_in    (sum_s[gi]),
            .valid_out (valid_s[gi+1]),
            .sub_out   (sub_s[gi+1]),
            .carry_out (carry_s[gi+1]),
            .tag_out   (tag_s[gi+1]),
            .a_out     (a_s[gi+1]),
            .b_out     (b_s[gi+1]),
            .sum_out   (sum_s[gi+1]),
            .cout_out  (cout_s[gi]),
            .ovf_out   (ovf_s[gi]),
            .zero_out  (zero_s[gi])
         );
      end
   endgenerate

   assign out_valid = valid_s[NUM_SEG];
   assign out_sum   = sum_s[NUM_SEG];
   assign out_tag   = tag_s[NUM_SEG];
   assign out_cout  = cout_s[NUM_SEG-1];
   assign out_ovf   = ovf_s[NUM_SEG-1];
   assign out_zero  = zero_s[NUM_SEG-1];

endmodule
